// File: rtl/harris_response.sv
// Harris corner response: captures 3x3 gradient products on the Sobel cadence,
// window-sums them, computes R = det(M) - k*trace(M)^2, thresholds and counts corners.
module harris_response #(
  parameter logic [7:0]         K_NUM   = 8'd5,
  parameter int                 K_SHIFT = 7,
  parameter logic signed [63:0] THRESH  = 64'sd100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [39:0] OIx0,
  input  logic signed [39:0] OIx1,
  input  logic signed [39:0] OIx2,
  input  logic signed [39:0] OIx3,
  input  logic signed [39:0] OIx4,
  input  logic signed [39:0] OIx5,
  input  logic signed [39:0] OIx6,
  input  logic signed [39:0] OIx7,
  input  logic signed [39:0] OIx8,
  input  logic signed [39:0] OIy0,
  input  logic signed [39:0] OIy1,
  input  logic signed [39:0] OIy2,
  input  logic signed [39:0] OIy3,
  input  logic signed [39:0] OIy4,
  input  logic signed [39:0] OIy5,
  input  logic signed [39:0] OIy6,
  input  logic signed [39:0] OIy7,
  input  logic signed [39:0] OIy8,
  input  logic signed [39:0] OIxy0,
  input  logic signed [39:0] OIxy1,
  input  logic signed [39:0] OIxy2,
  input  logic signed [39:0] OIxy3,
  input  logic signed [39:0] OIxy4,
  input  logic signed [39:0] OIxy5,
  input  logic signed [39:0] OIxy6,
  input  logic signed [39:0] OIxy7,
  input  logic signed [39:0] OIxy8,
  input  logic               count_clr,
  output logic               out_valid,
  output logic signed [63:0] resp,
  output logic               corner,
  output logic [15:0]        corner_count
);

  function automatic logic signed [43:0] sext44(input logic signed [39:0] v);
    return $signed({{4{v[39]}}, v});
  endfunction

  function automatic logic signed [63:0] sat64(input logic signed [99:0] v);
    if (v[99] && !(&v[98:63]))
      return {1'b1, 63'd0};
    else if (!v[99] && (|v[98:63]))
      return {1'b0, {63{1'b1}}};
    else
      return v[63:0];
  endfunction

  logic signed [39:0] ix_in [9];
  logic signed [39:0] iy_in [9];
  logic signed [39:0] ixy_in [9];

  always_comb begin
    ix_in  = '{OIx0, OIx1, OIx2, OIx3, OIx4, OIx5, OIx6, OIx7, OIx8};
    iy_in  = '{OIy0, OIy1, OIy2, OIy3, OIy4, OIy5, OIy6, OIy7, OIy8};
    ixy_in = '{OIxy0, OIxy1, OIxy2, OIxy3, OIxy4, OIxy5, OIxy6, OIxy7, OIxy8};
  end

  // Upstream refreshes its products on alternate cycles; capture only on phase 0.
  logic phase_q;
  logic cap;
  assign cap = !phase_q && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_q <= 1'b1;
    else     phase_q <= !phase_q;
  end

  // ---- Stage 1: capture ----
  logic signed [39:0] ix_p1_q [9];
  logic signed [39:0] iy_p1_q [9];
  logic signed [39:0] ixy_p1_q [9];
  logic               vld_p1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        ix_p1_q[i]  <= '0;
        iy_p1_q[i]  <= '0;
        ixy_p1_q[i] <= '0;
      end
    end else begin
      vld_p1_q <= cap;
      if (cap) begin
        ix_p1_q  <= ix_in;
        iy_p1_q  <= iy_in;
        ixy_p1_q <= ixy_in;
      end
    end
  end

  // ---- Stage 2: window sums ----
  logic signed [43:0] sxx_d, syy_d, sxy_d;
  logic signed [43:0] sxx_p2_q, syy_p2_q, sxy_p2_q;
  logic               vld_p2_q;

  always_comb begin
    sxx_d = '0;
    syy_d = '0;
    sxy_d = '0;
    for (int i = 0; i < 9; i++) begin
      sxx_d = sxx_d + sext44(ix_p1_q[i]);
      syy_d = syy_d + sext44(iy_p1_q[i]);
      sxy_d = sxy_d + sext44(ixy_p1_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      sxx_p2_q <= '0;
      syy_p2_q <= '0;
      sxy_p2_q <= '0;
    end else begin
      vld_p2_q <= vld_p1_q;
      sxx_p2_q <= sxx_d;
      syy_p2_q <= syy_d;
      sxy_p2_q <= sxy_d;
    end
  end

  // ---- Stage 3: determinant and squared trace ----
  logic signed [88:0] sxx_w, syy_w, sxy_w;
  logic signed [44:0] tr;
  logic signed [89:0] tr_w;
  logic signed [88:0] det_d;
  logic [89:0]        tr2_d;
  logic signed [88:0] det_p3_q;
  logic [89:0]        tr2_p3_q;
  logic               vld_p3_q;

  always_comb begin
    sxx_w = $signed({{45{sxx_p2_q[43]}}, sxx_p2_q});
    syy_w = $signed({{45{syy_p2_q[43]}}, syy_p2_q});
    sxy_w = $signed({{45{sxy_p2_q[43]}}, sxy_p2_q});
    det_d = sxx_w * syy_w - sxy_w * sxy_w;
    tr    = $signed({sxx_p2_q[43], sxx_p2_q}) + $signed({syy_p2_q[43], syy_p2_q});
    tr_w  = $signed({{45{tr[44]}}, tr});
    tr2_d = tr_w * tr_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p3_q <= 1'b0;
      det_p3_q <= '0;
      tr2_p3_q <= '0;
    end else begin
      vld_p3_q <= vld_p2_q;
      det_p3_q <= det_d;
      tr2_p3_q <= tr2_d;
    end
  end

  // ---- Stage 4: response, threshold, corner counter ----
  logic [97:0]        kmul;
  logic [97:0]        kt;
  logic signed [99:0] r;
  logic signed [63:0] resp_d;
  logic               corner_d;
  logic [15:0]        count_d;
  logic signed [63:0] resp_q;
  logic               corner_q;
  logic               out_valid_q;
  logic [15:0]        count_q;

  always_comb begin
    kmul     = {8'd0, tr2_p3_q} * {90'd0, K_NUM};
    kt       = kmul >> K_SHIFT;
    r        = $signed({{11{det_p3_q[88]}}, det_p3_q}) - $signed({2'b00, kt});
    resp_d   = sat64(r);
    corner_d = (resp_d > THRESH);
    count_d  = count_q;
    if (count_clr)
      count_d = '0;
    else if (vld_p3_q && corner_d && (count_q != 16'hFFFF))
      count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      resp_q      <= '0;
      corner_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      out_valid_q <= vld_p3_q;
      count_q     <= count_d;
      if (vld_p3_q) begin
        resp_q   <= resp_d;
        corner_q <= corner_d;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign resp         = resp_q;
  assign corner       = corner_q;
  assign corner_count = count_q;

endmodule

// File: tb/tb_harris_response.sv
// Directed bench for harris_response: hand-computed responses, latency,
// phase gating, saturation, counter behaviour and mid-flight reset.
module tb_harris_response;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               count_clr;
  logic signed [39:0] ix [9];
  logic signed [39:0] iy [9];
  logic signed [39:0] ixy [9];
  logic               out_valid;
  logic signed [63:0] resp;
  logic               corner;
  logic [15:0]        corner_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic phase_m;

  localparam logic signed [39:0] PMAX   = 40'sd549755813887;
  localparam logic signed [63:0] R_MAX  = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [63:0] R_MIN  = 64'sh8000_0000_0000_0000;

  harris_response dut (
    .clk(clk), .rst(rst), .start(start),
    .OIx0(ix[0]), .OIx1(ix[1]), .OIx2(ix[2]), .OIx3(ix[3]), .OIx4(ix[4]),
    .OIx5(ix[5]), .OIx6(ix[6]), .OIx7(ix[7]), .OIx8(ix[8]),
    .OIy0(iy[0]), .OIy1(iy[1]), .OIy2(iy[2]), .OIy3(iy[3]), .OIy4(iy[4]),
    .OIy5(iy[5]), .OIy6(iy[6]), .OIy7(iy[7]), .OIy8(iy[8]),
    .OIxy0(ixy[0]), .OIxy1(ixy[1]), .OIxy2(ixy[2]), .OIxy3(ixy[3]), .OIxy4(ixy[4]),
    .OIxy5(ixy[5]), .OIxy6(ixy[6]), .OIxy7(ixy[7]), .OIxy8(ixy[8]),
    .count_clr(count_clr),
    .out_valid(out_valid), .resp(resp), .corner(corner), .corner_count(corner_count)
  );

  always #5 clk = ~clk;

  // Phase model: value at the next rising edge decides whether that edge captures.
  always @(posedge clk or posedge rst) begin
    if (rst) phase_m <= 1'b1;
    else     phase_m <= ~phase_m;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic signed [39:0] x, input logic signed [39:0] y,
                        input logic signed [39:0] xy);
    for (int i = 0; i < 9; i++) begin
      ix[i]  = x;
      iy[i]  = y;
      ixy[i] = xy;
    end
  endtask

  // One window captured at a phase-0 edge E; result must appear after edge E+3.
  task automatic run_window(input string tag, input logic signed [39:0] x,
                            input logic signed [39:0] y, input logic signed [39:0] xy,
                            input bit clr, input logic signed [63:0] exp_resp,
                            input logic exp_corner, input logic [15:0] exp_cnt);
    int lat;
    logic signed [63:0] r_s;
    logic c_s;
    logic [15:0] n_s;
    lat = -1;
    r_s = '0;
    c_s = 1'b0;
    n_s = '0;
    @(negedge clk);
    while (phase_m != 1'b0) @(negedge clk);
    set_in(x, y, xy);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    set_in(40'sd7, -40'sd3, 40'sd11);
    for (int k = 1; k <= 6 && lat < 0; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        r_s = resp;
        c_s = corner;
        n_s = corner_count;
      end
      count_clr = clr && (k == 2);
    end
    count_clr = 1'b0;
    check({tag, "_latency"}, lat, 3);
    check({tag, "_resp"}, r_s, exp_resp);
    check({tag, "_corner"}, c_s, exp_corner);
    check({tag, "_count"}, n_s, exp_cnt);
    @(negedge clk);
    check({tag, "_pulse_end"}, out_valid, 0);
  endtask

  initial begin
    int pulses;
    int first_n;
    int last_n;
    bit spacing_ok;
    rst = 1'b1;
    start = 1'b0;
    count_clr = 1'b0;
    set_in('0, '0, '0);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_resp", resp, 0);
    check("rst_corner", corner, 0);
    check("rst_count", corner_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // det=810000, kt=floor(3240000*5/128)=126562
    run_window("flat", 40'sd100, 40'sd100, 40'sd0, 1'b0, 64'sd683438, 1'b1, 16'd1);
    // det=0, kt=floor(810000*5/128)=31640
    run_window("edge", 40'sd100, 40'sd0, 40'sd0, 1'b0, -64'sd31640, 1'b0, 16'd1);
    run_window("sat_pos", PMAX, PMAX, 40'sd0, 1'b0, R_MAX, 1'b1, 16'd2);
    run_window("sat_neg", 40'sd0, 40'sd0, PMAX, 1'b0, R_MIN, 1'b0, 16'd2);

    // Start for one cycle on a phase-1 edge never captures.
    @(negedge clk);
    while (phase_m != 1'b1) @(negedge clk);
    set_in(40'sd100, 40'sd100, 40'sd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("gate_no_valid", pulses, 0);
    check("gate_count", corner_count, 2);

    // Start held six cycles from reset: captures on edges 2, 4, 6.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_in(40'sd100, 40'sd100, 40'sd0);
    start = 1'b1;
    pulses = 0;
    first_n = -1;
    last_n = -1;
    spacing_ok = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (out_valid) begin
        pulses++;
        if (first_n < 0) first_n = n;
        if (last_n >= 0 && n - last_n != 2) spacing_ok = 1'b0;
        last_n = n;
      end
      if (n == 6) start = 1'b0;
    end
    check("hold6_pulses", pulses, 3);
    check("hold6_first", first_n, 5);
    check("hold6_spacing", spacing_ok, 1);
    check("hold6_count", corner_count, 3);

    // Counter preload to one below full scale, then saturate.
    @(negedge clk);
    force dut.count_q = 16'hFFFE;
    #1;
    release dut.count_q;
    run_window("cnt_full", 40'sd100, 40'sd100, 40'sd0, 1'b0, 64'sd683438, 1'b1, 16'hFFFF);
    run_window("cnt_hold", 40'sd100, 40'sd100, 40'sd0, 1'b0, 64'sd683438, 1'b1, 16'hFFFF);
    run_window("cnt_clr", 40'sd100, 40'sd100, 40'sd0, 1'b1, 64'sd683438, 1'b1, 16'd0);
    run_window("cnt_restart", 40'sd100, 40'sd100, 40'sd0, 1'b0, 64'sd683438, 1'b1, 16'd1);

    // Reset one cycle after a capture wipes the window in flight.
    @(negedge clk);
    while (phase_m != 1'b0) @(negedge clk);
    set_in(40'sd100, 40'sd0, 40'sd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_resp", resp, 0);
    check("midrst_corner", corner, 0);
    check("midrst_count", corner_count, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("midrst_no_valid", pulses, 0);
    run_window("post_rst", 40'sd100, 40'sd0, 40'sd0, 1'b0, -64'sd31640, 1'b0, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
